uart_frame_parser: RTL

- Parametrised UART command-frame receiver for the IGBT controller, fed by the byte-level UART RX (recv_done/recv_data).
- Validates frames of the form: HDR0, HDR1, LEN, LEN payload bytes, CKH, CKL.
- Commits each good payload atomically to a flat register bank and answers with an ACK or NAK byte through the UART TX handshake (tx_busy/send_en).
- Adds checksum verification, length checking, an inter-byte timeout and statistics counters.

---
 rtl/uart_frame_parser.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - UART command-frame receiver with checksum, length check, timeout and ACK/NAK reply
module uart_frame_parser #(
    parameter logic [7:0] HDR0       = 8'hAF,
    parameter logic [7:0] HDR1       = 8'hFA,
    parameter int         MAX_LEN    = 16,
    parameter int         CLK_FREQ   = 50000000,
    parameter int         TIMEOUT_US = 1000,
    parameter logic [7:0] ACK_BYTE   = 8'h06,
    parameter logic [7:0] NAK_BYTE   = 8'h15
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   recv_done,
    input  logic [7:0]             recv_data,
    input  logic                   tx_busy,
    output logic                   send_en,
    output logic [7:0]             send_data,
    output logic                   frame_valid,
    output logic [7:0]             frame_len,
    output logic [MAX_LEN*8-1:0]   payload_flat,
    output logic                   err_chk,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            err_cnt
);

    localparam int TMO = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int TW  = $clog2(TMO + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_H1   = 3'd1;
    localparam logic [2:0] S_LN   = 3'd2;
    localparam logic [2:0] S_DT   = 3'd3;
    localparam logic [2:0] S_CH   = 3'd4;
    localparam logic [2:0] S_CL   = 3'd5;
    localparam logic [2:0] S_RSP  = 3'd6;

    logic                 d0_q, d1_q;
    logic [2:0]           state_q, state_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           idx_q, idx_d;
    logic [15:0]          sum_q, sum_d;
    logic [7:0]           ckh_q, ckh_d;
    logic [7:0]           resp_q, resp_d;
    logic [MAX_LEN*8-1:0] buf_q, buf_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 send_en_q, send_en_d;
    logic [7:0]           send_data_q, send_data_d;
    logic                 frame_valid_q, frame_valid_d;
    logic [7:0]           frame_len_q, frame_len_d;
    logic [MAX_LEN*8-1:0] payload_q, payload_d;
    logic                 err_chk_q, err_chk_d;
    logic                 err_len_q, err_len_d;
    logic                 err_tmo_q, err_tmo_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [15:0]          err_cnt_q, err_cnt_d;

    logic byte_stb;
    logic in_frame;

    assign byte_stb = d0_q & ~d1_q;
    assign in_frame = (state_q == S_H1) || (state_q == S_LN) || (state_q == S_DT) ||
                      (state_q == S_CH) || (state_q == S_CL);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        ckh_d         = ckh_q;
        resp_d        = resp_q;
        buf_d         = buf_q;
        tmo_d         = tmo_q;
        send_en_d     = 1'b0;
        send_data_d   = send_data_q;
        frame_valid_d = 1'b0;
        frame_len_d   = frame_len_q;
        payload_d     = payload_q;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_tmo_d     = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;

        // A byte arriving on the very cycle the gap limit is hit wins over the timeout.
        if (!in_frame || byte_stb) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TMO - 1)) begin
            tmo_d     = '0;
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (byte_stb && recv_data == HDR0) begin
                    state_d = S_H1;
                end
            end
            S_H1: begin
                if (byte_stb) begin
                    if (recv_data == HDR1) begin
                        state_d = S_LN;
                    end else if (recv_data == HDR0) begin
                        state_d = S_H1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_LN: begin
                if (byte_stb) begin
                    len_d = recv_data;
                    sum_d = {8'h00, recv_data};
                    buf_d = '0;
                    idx_d = 8'd0;
                    if (recv_data == 8'd0 || recv_data > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        resp_d    = NAK_BYTE;
                        state_d   = S_RSP;
                    end else begin
                        state_d = S_DT;
                    end
                end
            end
            S_DT: begin
                if (byte_stb) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == 8'(i)) begin
                            buf_d[i*8 +: 8] = recv_data;
                        end
                    end
                    sum_d = sum_q + {8'h00, recv_data};
                    if (idx_q == len_q - 8'd1) begin
                        state_d = S_CH;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_CH: begin
                if (byte_stb) begin
                    ckh_d   = recv_data;
                    state_d = S_CL;
                end
            end
            S_CL: begin
                if (byte_stb) begin
                    if ({ckh_q, recv_data} == sum_q) begin
                        payload_d     = buf_q;
                        frame_len_d   = len_q;
                        frame_valid_d = 1'b1;
                        resp_d        = ACK_BYTE;
                        if (frame_cnt_q != 16'hFFFF) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                    end else begin
                        err_chk_d = 1'b1;
                        resp_d    = NAK_BYTE;
                    end
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (!tx_busy) begin
                    send_en_d   = 1'b1;
                    send_data_d = resp_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((err_chk_d || err_len_d || err_tmo_d) && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d0_q          <= 1'b0;
            d1_q          <= 1'b0;
            state_q       <= S_IDLE;
            len_q         <= 8'd0;
            idx_q         <= 8'd0;
            sum_q         <= 16'd0;
            ckh_q         <= 8'd0;
            resp_q        <= 8'd0;
            buf_q         <= '0;
            tmo_q         <= '0;
            send_en_q     <= 1'b0;
            send_data_q   <= 8'd0;
            frame_valid_q <= 1'b0;
            frame_len_q   <= 8'd0;
            payload_q     <= '0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_tmo_q     <= 1'b0;
            frame_cnt_q   <= 16'd0;
            err_cnt_q     <= 16'd0;
        end else begin
            d0_q          <= recv_done;
            d1_q          <= d0_q;
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            ckh_q         <= ckh_d;
            resp_q        <= resp_d;
            buf_q         <= buf_d;
            tmo_q         <= tmo_d;
            send_en_q     <= send_en_d;
            send_data_q   <= send_data_d;
            frame_valid_q <= frame_valid_d;
            frame_len_q   <= frame_len_d;
            payload_q     <= payload_d;
            err_chk_q     <= err_chk_d;
            err_len_q     <= err_len_d;
            err_tmo_q     <= err_tmo_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign send_en      = send_en_q;
    assign send_data    = send_data_q;
    assign frame_valid  = frame_valid_q;
    assign frame_len    = frame_len_q;
    assign payload_flat = payload_q;
    assign err_chk      = err_chk_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_tmo_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule
